// File: rtl/sram_wait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_wait_ctrl
//  Purpose  : Word-addressed data memory with REQ/READY handshake,
//             programmable wait states, byte-enable writes and range error.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_wait_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 128,
    parameter int WAIT_CYC  = 0,
    parameter     INIT_FILE = ""
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ,
    input  logic                  WE,
    input  logic [DATA_W/8-1:0]   BE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [DATA_W-1:0]     WD,
    output logic                  READY,
    output logic                  ACK,
    output logic [DATA_W-1:0]     RD,
    output logic                  ERR
);

    localparam int                c_NBYTES    = DATA_W / 8;
    localparam int                c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        c_WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
    localparam logic [ADDR_W-1:0] c_DEPTH_A   = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [3:0]            r_cnt_q,   w_cnt_d;
    logic                  r_we_q,    w_we_d;
    logic [c_NBYTES-1:0]   r_be_q,    w_be_d;
    logic [ADDR_W-1:0]     r_addr_q,  w_addr_d;
    logic [DATA_W-1:0]     r_wd_q,    w_wd_d;
    logic                  r_ack_q,   w_ack_d;
    logic                  r_err_q,   w_err_d;
    logic [DATA_W-1:0]     r_rd_q,    w_rd_d;

    logic [DATA_W-1:0]     r_mem [DEPTH];

    logic                  w_in_range;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_mem_wr;

    // Range test uses the full address so out-of-range words never alias.
    assign w_in_range = (r_addr_q < c_DEPTH_A);
    assign w_idx      = r_addr_q[c_IDX_W-1:0];
    assign w_mem_wr   = (r_state_q == ST_ACCESS) && r_we_q && w_in_range;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_we_d    = r_we_q;
        w_be_d    = r_be_q;
        w_addr_d  = r_addr_q;
        w_wd_d    = r_wd_q;
        w_ack_d   = 1'b0;
        w_err_d   = 1'b0;
        w_rd_d    = r_rd_q;
        case (r_state_q)
            ST_IDLE: begin
                if (REQ) begin
                    w_we_d   = WE;
                    w_be_d   = BE;
                    w_addr_d = ADDRESS;
                    w_wd_d   = WD;
                    if (WAIT_CYC > 0) begin
                        w_state_d = ST_WAIT;
                        w_cnt_d   = c_WAIT_LOAD;
                    end else begin
                        w_state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d = ST_ACCESS;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                w_state_d = ST_IDLE;
                w_ack_d   = 1'b1;
                w_err_d   = ~w_in_range;
                if (!r_we_q) begin
                    w_rd_d = w_in_range ? r_mem[w_idx] : '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= 4'd0;
            r_we_q    <= 1'b0;
            r_be_q    <= '0;
            r_addr_q  <= '0;
            r_wd_q    <= '0;
            r_ack_q   <= 1'b0;
            r_err_q   <= 1'b0;
            r_rd_q    <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_we_q    <= w_we_d;
            r_be_q    <= w_be_d;
            r_addr_q  <= w_addr_d;
            r_wd_q    <= w_wd_d;
            r_ack_q   <= w_ack_d;
            r_err_q   <= w_err_d;
            r_rd_q    <= w_rd_d;
        end
    end

    // Storage is deliberately not reset; only enabled bytes are updated.
    always_ff @(posedge CLK) begin
        if (w_mem_wr) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (r_be_q[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wd_q[8*i +: 8];
                end
            end
        end
    end

    assign READY = (r_state_q == ST_IDLE);
    assign ACK   = r_ack_q;
    assign ERR   = r_err_q;
    assign RD    = r_rd_q;

endmodule
`default_nettype wire
